ik_iter_ctrl: RTL and testbench

IK_ITER_CTRL -- requirements
Module: ik_iter_ctrl

---
 rtl/ik_ctrl_pkg.sv | 18 +
 rtl/ik_abs_max.sv | 37 +++
 rtl/ik_iter_ctrl.sv | 133 +++++++++++++
 tb/tb_ik_iter_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ik_ctrl_pkg.sv
// ik_ctrl_pkg
// Shared definitions for the IK iteration controller.
//   state_t           : controller FSM states
//   ITER_LEN_DEFAULT  : default number of clock cycles per IK iteration
//   W_DEFAULT         : default width of the delta / tolerance values
package ik_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ITER_LEN_DEFAULT = 250;
  localparam int W_DEFAULT        = 36;

endpackage

// File: rtl/ik_abs_max.sv
// ik_abs_max
// Combinational maximum of the absolute values of six signed joint deltas.
// The absolute value saturates, so the most negative input maps to
// 2^(W-1)-1 and the result always fits in W unsigned bits.
//   W       : width of each delta
//   delta   : six signed two's-complement deltas, packed [5:0][W-1:0]
//   max_abs : unsigned maximum of |delta[j]| over all six joints
module ik_abs_max
  import ik_ctrl_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [5:0][W-1:0] delta,
  output logic [W-1:0]      max_abs
);

  logic [W-1:0] abs_val;

  always_comb begin
    max_abs = '0;
    abs_val = '0;
    for (int j = 0; j < 6; j++) begin
      if (delta[j][W-1] && (delta[j][W-2:0] == '0)) begin
        // Most negative value has no positive counterpart; clamp it.
        abs_val = {1'b0, {(W-1){1'b1}}};
      end else if (delta[j][W-1]) begin
        abs_val = (~delta[j]) + {{(W-1){1'b0}}, 1'b1};
      end else begin
        abs_val = delta[j];
      end
      if (abs_val > max_abs) begin
        max_abs = abs_val;
      end
    end
  end

endmodule

// File: rtl/ik_iter_ctrl.sv
// ik_iter_ctrl
// Sequences an external IK core through repeated fixed-length iterations
// until the largest joint update falls within tolerance or an iteration
// limit is reached.
//   clk, rst           : clock and synchronous active-high reset
//   start              : begin a run (honoured only in IDLE or DONE)
//   abort              : stop a run and return to IDLE (beats start)
//   max_iter           : iteration limit, latched on start (0 acts as 1)
//   tol                : unsigned convergence threshold, latched on start
//   delta              : six signed per-joint updates from the IK core
//   core_en, core_rst  : enable / reset for the IK core
//   busy, done         : run status (busy in CLEAR and RUN, done in DONE)
//   converged          : last run ended because max |delta| <= tol
//   iter_count         : completed iterations, saturating at 255
//   max_abs_delta      : max |delta| captured at the last iteration boundary
module ik_iter_ctrl
  import ik_ctrl_pkg::*;
#(
  parameter int ITER_LEN = ITER_LEN_DEFAULT,
  parameter int W        = W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        max_iter,
  input  logic [W-1:0]      tol,
  input  logic [5:0][W-1:0] delta,
  output logic              core_en,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [7:0]        iter_count,
  output logic [W-1:0]      max_abs_delta
);

  localparam int PW = (ITER_LEN > 1) ? $clog2(ITER_LEN) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(ITER_LEN - 1);

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] phase;
  logic [7:0]    limit;
  logic [W-1:0]  tol_q;
  logic [W-1:0]  m;
  logic          boundary;
  logic          conv_hit;
  logic [7:0]    iter_inc;

  ik_abs_max #(.W(W)) u_abs_max (
    .delta   (delta),
    .max_abs (m)
  );

  assign boundary = (state == RUN) && (phase == LAST_PHASE);
  assign conv_hit = (m <= tol_q);
  assign iter_inc = (iter_count == 8'hFF) ? 8'hFF : iter_count + 8'd1;

  // Abort outranks start everywhere; start is only honoured when not busy.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!abort && start) state_next = CLEAR;
      end
      CLEAR: begin
        state_next = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (boundary && (conv_hit || (iter_inc >= limit))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (start) begin
          state_next = CLEAR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      phase         <= '0;
      limit         <= '0;
      tol_q         <= '0;
      core_en       <= 1'b0;
      core_rst      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      converged     <= 1'b0;
      iter_count    <= '0;
      max_abs_delta <= '0;
    end else begin
      state    <= state_next;
      core_en  <= (state_next == RUN);
      core_rst <= (state_next == CLEAR);
      busy     <= (state_next == CLEAR) || (state_next == RUN);
      done     <= (state_next == DONE);

      if ((state == RUN) && (state_next == RUN)) begin
        phase <= boundary ? '0 : phase + 1'b1;
      end else begin
        phase <= '0;
      end

      // CLEAR is only ever entered from an accepted start.
      if (state_next == CLEAR) begin
        limit      <= (max_iter == 8'd0) ? 8'd1 : max_iter;
        tol_q      <= tol;
        iter_count <= '0;
        converged  <= 1'b0;
      end

      // An abort landing on the boundary leaves the statistics untouched.
      if (boundary && !abort) begin
        max_abs_delta <= m;
        iter_count    <= iter_inc;
        if (conv_hit) converged <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ik_iter_ctrl.sv
// tb_ik_iter_ctrl
// Directed self-checking bench for ik_iter_ctrl with the default
// ITER_LEN=250 and W=36. Inputs change and outputs are sampled 1 time unit
// after each rising clock edge.
module tb_ik_iter_ctrl;

  localparam int W = 36;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [7:0]        max_iter;
  logic [W-1:0]      tol;
  logic [5:0][W-1:0] delta;
  logic              core_en;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              converged;
  logic [7:0]        iter_count;
  logic [W-1:0]      max_abs_delta;

  int checks;
  int failures;
  int cycles;

  ik_iter_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .max_iter      (max_iter),
    .tol           (tol),
    .delta         (delta),
    .core_en       (core_en),
    .core_rst      (core_rst),
    .busy          (busy),
    .done          (done),
    .converged     (converged),
    .iter_count    (iter_count),
    .max_abs_delta (max_abs_delta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start for one edge with the given limit and tolerance.
  task automatic applyStimulus(input logic [7:0] mi, input logic [W-1:0] t);
    max_iter = mi;
    tol      = t;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  // Count edges after the start edge until done rises, with a hard bound.
  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic setAllDelta(input logic [W-1:0] v);
    for (int j = 0; j < 6; j++) delta[j] = v;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_core_en"},  64'(core_en),       64'd0);
    checkOutput({tag, "_core_rst"}, 64'(core_rst),      64'd0);
    checkOutput({tag, "_busy"},     64'(busy),          64'd0);
    checkOutput({tag, "_done"},     64'(done),          64'd0);
    checkOutput({tag, "_conv"},     64'(converged),     64'd0);
    checkOutput({tag, "_iter"},     64'(iter_count),    64'd0);
    checkOutput({tag, "_mad"},      64'(max_abs_delta), 64'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    max_iter = 8'd0;
    tol      = '0;
    setAllDelta('0);
    waitEdges(2);
    checkAllZero("reset");
    rst = 1'b0;
    waitEdges(1);

    // One iteration converges: |-3| = 3 <= 16.
    setAllDelta(-36'sd3);
    applyStimulus(8'd5, 36'd16);
    checkOutput("clr_core_rst", 64'(core_rst), 64'd1);
    checkOutput("clr_core_en",  64'(core_en),  64'd0);
    checkOutput("clr_busy",     64'(busy),     64'd1);
    waitEdges(1);
    checkOutput("run_core_en",  64'(core_en),  64'd1);
    checkOutput("run_core_rst", 64'(core_rst), 64'd0);
    cycles = 1;
    waitDone(cycles);
    cycles = cycles + 1;
    checkOutput("conv1_cycles", 64'(cycles),        64'd251);
    checkOutput("conv1_conv",   64'(converged),     64'd1);
    checkOutput("conv1_iter",   64'(iter_count),    64'd1);
    checkOutput("conv1_mad",    64'(max_abs_delta), 64'd3);
    checkOutput("conv1_busy",   64'(busy),          64'd0);
    checkOutput("conv1_en",     64'(core_en),       64'd0);
    waitEdges(3);
    checkOutput("done_hold",    64'(done),          64'd1);

    // Restart from DONE with a tighter tolerance: 3 > 2, limit 2.
    applyStimulus(8'd2, 36'd2);
    checkOutput("rs_core_rst",  64'(core_rst),      64'd1);
    checkOutput("rs_done",      64'(done),          64'd0);
    checkOutput("rs_iter",      64'(iter_count),    64'd0);
    checkOutput("rs_conv",      64'(converged),     64'd0);
    waitEdges(1);
    checkOutput("rs_pulse_end", 64'(core_rst),      64'd0);
    waitDone(cycles);
    cycles = cycles + 1;
    checkOutput("rs_cycles",    64'(cycles),        64'd501);
    checkOutput("rs_conv2",     64'(converged),     64'd0);
    checkOutput("rs_iter2",     64'(iter_count),    64'd2);

    // Limit reached after three iterations.
    setAllDelta('0);
    delta[2] = 36'd100;
    applyStimulus(8'd3, 36'd0);
    waitDone(cycles);
    checkOutput("lim_cycles",   64'(cycles),        64'd751);
    checkOutput("lim_conv",     64'(converged),     64'd0);
    checkOutput("lim_iter",     64'(iter_count),    64'd3);
    checkOutput("lim_mad",      64'(max_abs_delta), 64'd100);

    // Most negative delta saturates to 2^35-1.
    setAllDelta('0);
    delta[0] = 36'h8_0000_0000;
    applyStimulus(8'd4, 36'h7_FFFF_FFFF);
    waitDone(cycles);
    checkOutput("sat_cycles",   64'(cycles),        64'd251);
    checkOutput("sat_mad",      64'(max_abs_delta), 64'h7_FFFF_FFFF);
    checkOutput("sat_conv",     64'(converged),     64'd1);

    // Convergence at m == tol coinciding with a limit of 1.
    setAllDelta(-36'sd5);
    delta[3] = 36'd5;
    applyStimulus(8'd1, 36'd5);
    waitDone(cycles);
    checkOutput("coin_cycles",  64'(cycles),        64'd251);
    checkOutput("coin_conv",    64'(converged),     64'd1);
    checkOutput("coin_iter",    64'(iter_count),    64'd1);

    // Same deltas, tol one below: limit path only.
    applyStimulus(8'd1, 36'd4);
    waitDone(cycles);
    checkOutput("tol4_cycles",  64'(cycles),        64'd251);
    checkOutput("tol4_conv",    64'(converged),     64'd0);
    checkOutput("tol4_mad",     64'(max_abs_delta), 64'd5);

    // Start while busy is ignored; abort+start at phase 100 goes to IDLE.
    applyStimulus(8'd10, 36'd0);
    waitEdges(50);
    start = 1'b1;
    waitEdges(1);
    start = 1'b0;
    checkOutput("busy_start_rst", 64'(core_rst), 64'd0);
    checkOutput("busy_start_en",  64'(core_en),  64'd1);
    waitEdges(50);
    abort = 1'b1;
    start = 1'b1;
    waitEdges(1);
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort_en",     64'(core_en),       64'd0);
    checkOutput("abort_done",   64'(done),          64'd0);
    checkOutput("abort_busy",   64'(busy),          64'd0);
    checkOutput("abort_iter",   64'(iter_count),    64'd0);
    checkOutput("abort_mad",    64'(max_abs_delta), 64'd5);
    waitEdges(2);
    checkOutput("abort_idle",   64'(busy),          64'd0);

    // Reset at phase 57 overrides a simultaneous start.
    applyStimulus(8'd10, 36'd0);
    waitEdges(58);
    rst   = 1'b1;
    start = 1'b1;
    waitEdges(1);
    rst   = 1'b0;
    start = 1'b0;
    checkAllZero("midrst");
    waitEdges(1);

    // max_iter=0 behaves as a single iteration.
    setAllDelta('0);
    delta[5] = 36'd100;
    applyStimulus(8'd0, 36'd0);
    waitDone(cycles);
    checkOutput("mi0_cycles",   64'(cycles),        64'd251);
    checkOutput("mi0_iter",     64'(iter_count),    64'd1);
    checkOutput("mi0_conv",     64'(converged),     64'd0);
    checkOutput("mi0_mad",      64'(max_abs_delta), 64'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
